// File: rtl/pipe_stage_chain.sv
// Chain of STAGES valid/allow registers with result capture, masked flush and two-port register bypass.
// Latency STAGES cycles, 1/cycle; stall at stage k back-pressures stages 0..k combinationally, stages above drain.
module pipe_stage_chain #(
    parameter int STAGES = 4,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 5,
    parameter int RES_W  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_allow,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [TAG_W-1:0]        in_wtag,
    input  logic                    in_wen,
    input  logic [STAGES-1:0]       stage_stall,
    input  logic [STAGES-1:0]       flush_mask,
    input  logic [STAGES-1:0]       res_ready,
    input  logic [STAGES*RES_W-1:0] res_data,
    input  logic [TAG_W-1:0]        rtag0,
    input  logic [TAG_W-1:0]        rtag1,
    output logic                    fwd_hit0,
    output logic                    fwd_hit1,
    output logic [RES_W-1:0]        fwd_data0,
    output logic [RES_W-1:0]        fwd_data1,
    output logic                    fwd_stall,
    output logic                    out_valid,
    input  logic                    out_allow,
    output logic [DATA_W-1:0]       out_data,
    output logic [TAG_W-1:0]        out_wtag,
    output logic                    out_wen,
    output logic [RES_W-1:0]        out_res,
    output logic [STAGES-1:0]       debug_stage_valid
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  wtag;
        logic              wen;
    } entry_t;

    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] rvld;
    logic [STAGES-1:0] allow;
    logic [STAGES-1:0] ready_go;
    logic [STAGES-1:0] eff_rvld;
    logic [STAGES-1:0] ld_valid;
    logic [STAGES-1:0] ld_rvld;
    entry_t            ent     [STAGES];
    entry_t            ld_ent  [STAGES];
    logic [RES_W-1:0]  res     [STAGES];
    logic [RES_W-1:0]  eff_res [STAGES];
    logic [RES_W-1:0]  ld_res  [STAGES];
    logic              unres0;
    logic              unres1;

    assign ready_go = ~stage_stall;

    // allow ripples from the output back to stage 0 within the cycle
    always_comb begin
        logic a;
        a = out_allow;
        allow = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            a = ~valid[k] | (ready_go[k] & a);
            allow[k] = a;
        end
    end

    // a result arriving this cycle is usable immediately and travels with the entry
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            eff_rvld[k] = rvld[k] | res_ready[k];
            eff_res[k]  = rvld[k] ? res[k] : res_data[k*RES_W +: RES_W];
        end
    end

    always_comb begin
        ld_valid[0] = in_valid;
        ld_ent[0]   = '{data: in_data, wtag: in_wtag, wen: in_wen};
        ld_res[0]   = '0;
        ld_rvld[0]  = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            ld_valid[k] = valid[k-1] & ready_go[k-1];
            ld_ent[k]   = ent[k-1];
            ld_res[k]   = eff_res[k-1];
            ld_rvld[k]  = eff_rvld[k-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (allow[k]) begin
                ent[k] <= ld_ent[k];
                res[k] <= ld_res[k];
            end else if (valid[k] & ~rvld[k] & res_ready[k]) begin
                res[k] <= res_data[k*RES_W +: RES_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            rvld  <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (allow[k]) begin
                    valid[k] <= ld_valid[k] & ~flush_mask[k];
                    rvld[k]  <= ld_rvld[k];
                end else begin
                    valid[k] <= valid[k] & ~flush_mask[k];
                    rvld[k]  <= rvld[k] | (valid[k] & res_ready[k]);
                end
            end
        end
    end

    // scan oldest to youngest so the youngest matching writer wins
    always_comb begin
        fwd_hit0  = 1'b0;
        fwd_hit1  = 1'b0;
        fwd_data0 = '0;
        fwd_data1 = '0;
        unres0    = 1'b0;
        unres1    = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (valid[k] && ent[k].wen && ent[k].wtag == rtag0 && rtag0 != '0) begin
                fwd_hit0  = 1'b1;
                fwd_data0 = eff_rvld[k] ? eff_res[k] : '0;
                unres0    = ~eff_rvld[k];
            end
            if (valid[k] && ent[k].wen && ent[k].wtag == rtag1 && rtag1 != '0) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = eff_rvld[k] ? eff_res[k] : '0;
                unres1    = ~eff_rvld[k];
            end
        end
    end

    assign fwd_stall         = unres0 | unres1;
    assign in_allow          = allow[0];
    assign out_valid         = valid[STAGES-1];
    assign out_data          = ent[STAGES-1].data;
    assign out_wtag          = ent[STAGES-1].wtag;
    assign out_wen           = valid[STAGES-1] & ent[STAGES-1].wen;
    assign out_res           = eff_res[STAGES-1];
    assign debug_stage_valid = valid;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Random and directed stimulus against a slot-level reference model; outputs checked by a scoreboard monitor.
module tb_pipe_stage_chain;
    localparam int S   = 4;
    localparam int DW  = 64;
    localparam int TW  = 5;
    localparam int RW  = 32;
    localparam int NID = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          in_valid = 1'b0, in_allow, in_wen = 1'b0, out_allow = 1'b1;
    logic [DW-1:0] in_data = '0, out_data;
    logic [TW-1:0] in_wtag = '0, rtag0 = '0, rtag1 = '0, out_wtag;
    logic [S-1:0]  stage_stall = '0, flush_mask = '0, res_ready = '0, debug_stage_valid;
    logic [S*RW-1:0] res_data = '0;
    logic          fwd_hit0, fwd_hit1, fwd_stall, out_valid, out_wen;
    logic [RW-1:0] fwd_data0, fwd_data1, out_res;

    pipe_stage_chain #(.STAGES(S), .DATA_W(DW), .TAG_W(TW), .RES_W(RW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_allow(in_allow), .in_data(in_data),
        .in_wtag(in_wtag), .in_wen(in_wen), .stage_stall(stage_stall), .flush_mask(flush_mask),
        .res_ready(res_ready), .res_data(res_data), .rtag0(rtag0), .rtag1(rtag1),
        .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1), .fwd_data0(fwd_data0), .fwd_data1(fwd_data1),
        .fwd_stall(fwd_stall), .out_valid(out_valid), .out_allow(out_allow), .out_data(out_data),
        .out_wtag(out_wtag), .out_wen(out_wen), .out_res(out_res), .debug_stage_valid(debug_stage_valid)
    );

    int total = 0;
    int bad = 0;

    // entry catalogue: every entry has an id, its fields and its eventual result
    logic [DW-1:0] data_of [NID];
    logic [TW-1:0] tag_of  [NID];
    bit            wen_of  [NID];
    logic [RW-1:0] res_of  [NID];
    bit            dropped [NID];
    int            q[$];
    int            next_id = 1;

    // pipeline occupancy: which entry sits in each slot and whether its result is known
    bit mv  [S];
    int mid [S];
    bit mrv [S];
    bit mal [0:S];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic new_entry(input logic [TW-1:0] tag, input bit wen, input logic [RW-1:0] r);
        if (next_id < NID) begin
            data_of[next_id] = {$urandom, $urandom};
            tag_of[next_id]  = tag;
            wen_of[next_id]  = wen;
            res_of[next_id]  = r;
        end
    endtask

    task automatic calc_allow();
        mal[S] = out_allow;
        for (int k = S - 1; k >= 0; k--) mal[k] = !mv[k] || (!stage_stall[k] && mal[k+1]);
    endtask

    task automatic fwd_model(input logic [TW-1:0] rt, output bit hit, output logic [RW-1:0] d, output bit st);
        hit = 0; d = '0; st = 0;
        if (rt != 0) begin
            for (int k = 0; k < S; k++) begin
                if (mv[k] && wen_of[mid[k]] && tag_of[mid[k]] == rt) begin
                    hit = 1;
                    if (mrv[k] || res_ready[k]) d = res_of[mid[k]];
                    else st = 1;
                    break;
                end
            end
        end
    endtask

    task automatic ctrl_idle();
        in_valid = 0; stage_stall = '0; flush_mask = '0; res_ready = '0;
        out_allow = 1; rtag0 = '0; rtag1 = '0;
    endtask

    // drive this cycle's inputs, then compare combinational outputs with the model
    task automatic settle();
        bit h0, h1, s0, s1;
        logic [RW-1:0] d0, d1;
        logic [S-1:0] sv;
        in_data = data_of[next_id];
        in_wtag = tag_of[next_id];
        in_wen  = wen_of[next_id];
        for (int k = 0; k < S; k++) res_data[k*RW +: RW] = mv[k] ? res_of[mid[k]] : '0;
        #1;
        calc_allow();
        for (int k = 0; k < S; k++) sv[k] = mv[k];
        check("in_allow", in_allow, mal[0]);
        check("stage_valid", debug_stage_valid, sv);
        check("out_valid", out_valid, mv[S-1]);
        check("out_wen", out_wen, mv[S-1] && wen_of[mid[S-1]]);
        fwd_model(rtag0, h0, d0, s0);
        fwd_model(rtag1, h1, d1, s1);
        check("fwd_hit0", fwd_hit0, h0);
        check("fwd_data0", fwd_data0, d0);
        check("fwd_hit1", fwd_hit1, h1);
        check("fwd_data1", fwd_data1, d1);
        check("fwd_stall", fwd_stall, s0 || s1);
    endtask

    task automatic tick();
        bit nv [S];
        int nid [S];
        bit nrv [S];
        bit acc;
        @(posedge clk);
        calc_allow();
        if (reset) begin
            for (int k = 0; k < S; k++) begin
                if (mv[k]) dropped[mid[k]] = 1;
                mv[k] = 0; mrv[k] = 0;
            end
        end else begin
            acc = in_valid && mal[0];
            if (acc) q.push_back(next_id);
            for (int k = 0; k < S; k++) begin
                if (mal[k]) begin
                    if (k == 0) begin nv[k] = in_valid; nid[k] = next_id; nrv[k] = 0; end
                    else begin
                        nv[k]  = mv[k-1] && !stage_stall[k-1];
                        nid[k] = mid[k-1];
                        nrv[k] = mrv[k-1] || res_ready[k-1];
                    end
                end else begin
                    nv[k] = mv[k]; nid[k] = mid[k]; nrv[k] = mrv[k] || (mv[k] && res_ready[k]);
                end
                if (flush_mask[k]) begin
                    if (nv[k]) dropped[nid[k]] = 1;
                    nv[k] = 0;
                end
            end
            for (int k = 0; k < S; k++) begin mv[k] = nv[k]; mid[k] = nid[k]; mrv[k] = nrv[k]; end
            if (acc && next_id < NID - 1) next_id++;
        end
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1;
            new_entry(5'(10 + i), 1, $urandom);
            cycle();
        end
        in_valid = 0;
    endtask

    // scoreboard monitor: every output transfer must match the oldest surviving entry
    initial begin
        int id;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && out_valid === 1'b1 && out_allow && !stage_stall[S-1]) begin
                while (q.size() > 0 && dropped[q[0]]) void'(q.pop_front());
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL scoreboard: output tag %0h with no expected entry", out_wtag);
                end else begin
                    id = q.pop_front();
                    check("out_data", out_data, data_of[id]);
                    check("out_wtag", out_wtag, tag_of[id]);
                    check("out_res", out_res, res_of[id]);
                end
            end
        end
    end

    initial begin
        int left;
        @(negedge clk);
        ctrl_idle();
        reset = 1;
        tick();
        reset = 0;
        rtag0 = 5'd3;
        settle();
        check("rst_stage_valid", debug_stage_valid, 0);
        check("rst_in_allow", in_allow, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_fwd_hit0", fwd_hit0, 0);
        tick();

        // streaming tags 1..8: first output after 4 cycles, then back to back
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 8);
            if (c < 8) new_entry(5'(c + 1), 1, $urandom);
            settle();
            check("stream_out_valid", out_valid, (c >= 4 && c < 12));
            if (c >= 4 && c < 12) check("stream_tag", out_wtag, c - 3);
            tick();
        end

        // stall at stage 2 with a full pipe
        fill(4);
        for (int c = 0; c < 6; c++) begin
            stage_stall = (c < 3) ? 4'b0100 : 4'b0000;
            in_valid = (c < 3);
            if (c < 3) new_entry(5'(20 + c), 0, $urandom);
            settle();
            if (c < 3) check("stall_in_allow", in_allow, 0);
            check("stall_out_valid", out_valid, (c == 0 || c >= 4));
            tick();
        end
        ctrl_idle();
        for (int i = 0; i < 6; i++) cycle();

        // forwarding from a stalled stage 1 entry before and after its result arrives
        in_valid = 1; new_entry(5'd5, 1, 32'hDEAD); cycle();
        in_valid = 0; cycle();
        stage_stall = 4'b0010; rtag0 = 5'd5;
        settle();
        check("fwd_pending_hit", fwd_hit0, 1);
        check("fwd_pending_stall", fwd_stall, 1);
        tick();
        res_ready = 4'b0010;
        settle();
        check("fwd_same_cycle", fwd_data0, 32'hDEAD);
        check("fwd_resolved", fwd_stall, 0);
        tick();
        res_ready = '0; stage_stall = '0;
        settle();
        check("fwd_captured", fwd_data0, 32'hDEAD);
        tick();
        settle();
        check("fwd_persist", fwd_data0, 32'hDEAD);
        tick();
        ctrl_idle();
        for (int i = 0; i < 6; i++) cycle();

        // youngest writer wins; register 0 never forwards
        in_valid = 1;
        new_entry(5'd7, 1, 32'h22); cycle();
        new_entry(5'd3, 1, 32'h33); cycle();
        new_entry(5'd7, 1, 32'h11); cycle();
        in_valid = 0; res_ready = 4'b1111; rtag1 = 5'd7; rtag0 = 5'd0;
        settle();
        check("young_hit", fwd_hit1, 1);
        check("young_data", fwd_data1, 32'h11);
        check("rtag0_zero_hit", fwd_hit0, 0);
        tick();
        ctrl_idle();
        for (int i = 0; i < 6; i++) cycle();

        // flush stages 0..1 while everything advances
        in_valid = 1;
        new_entry(5'd1, 1, $urandom); cycle();
        new_entry(5'd2, 1, $urandom); cycle();
        new_entry(5'd3, 1, $urandom); cycle();
        new_entry(5'd9, 1, $urandom); cycle();
        new_entry(5'd4, 1, $urandom);
        flush_mask = 4'b0011; rtag0 = 5'd9;
        settle();
        check("flush_in_allow", in_allow, 1);
        check("flush_pre_hit", fwd_hit0, 1);
        tick();
        flush_mask = '0; in_valid = 0;
        settle();
        check("flush_valid", debug_stage_valid, 4'b1100);
        check("flush_no_hit", fwd_hit0, 0);
        tick();
        ctrl_idle();
        for (int i = 0; i < 6; i++) cycle();

        // reset with a full, stalled pipe
        fill(4);
        stage_stall = 4'b0110; reset = 1;
        cycle();
        reset = 0;
        settle();
        check("midrst_valid", debug_stage_valid, 0);
        check("midrst_in_allow", in_allow, 1);
        check("midrst_out_valid", out_valid, 0);
        tick();
        ctrl_idle();

        // random traffic
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            new_entry(5'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), $urandom);
            for (int k = 0; k < S; k++) begin
                stage_stall[k] = ($urandom_range(0, 5) == 0);
                res_ready[k]   = ($urandom_range(0, 2) == 0);
            end
            flush_mask = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            out_allow  = ($urandom_range(0, 4) != 0);
            rtag0 = 5'($urandom_range(0, 7));
            rtag1 = 5'($urandom_range(0, 7));
            cycle();
        end
        ctrl_idle();
        for (int i = 0; i < 10; i++) cycle();

        left = 0;
        foreach (q[i]) if (!dropped[q[i]]) left++;
        check("leftover_entries", left, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised chain of STAGES valid/allow pipeline registers, each carrying a DATA_W payload, a register-write tag and a captured result. It provides per-stage stall, masked flush and a two-port register-bypass lookup with load-use stall detection. It is the generic successor to the hand-wired IF/ID/EX/MEM/WB stage registers and forwarding tags. The CPU top instantiates it between decode and writeback.

## Interface
- STAGES, 4: number of pipeline registers; legal range 2..8.
- DATA_W, 64: opaque payload width (pc, control bits).
- TAG_W, 5: register-number width.
- RES_W, 32: result width.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream offers an entry.
- in_allow  out  1  stage 0 can accept this cycle.
- in_data  in  DATA_W  payload.
- in_wtag  in  TAG_W  destination register.
- in_wen  in  1  entry writes a register.
- stage_stall  in  STAGES  bit k: stage k is not ready to go.
- flush_mask  in  STAGES  bit k: invalidate stage k at the next edge.
- res_ready  in  STAGES  bit k: stage k's result is produced this cycle.
- res_data  in  STAGES*RES_W  slice k: result of stage k.
- rtag0, rtag1  in  TAG_W  source registers being read by decode.
- fwd_hit0, fwd_hit1  out  1  matching in-flight writer found.
- fwd_data0, fwd_data1  out  RES_W  bypass value.
- fwd_stall  out  1  a matching writer exists but has no result yet.
- out_valid  out  1  last stage holds an entry.
- out_allow  in  1  downstream accepts.
- out_data  out  DATA_W  last-stage payload.
- out_wtag  out  TAG_W  last-stage tag.
- out_wen  out  1  last-stage write enable. Gated by out_valid.
- out_res  out  RES_W  last-stage result.
- debug_stage_valid  out  STAGES  valid bit of every stage.

## Operation
- Per-stage state: valid_k, data_k, wtag_k, wen_k, res_k, rvld_k.
- Handshake:
  - ready_go_k = ~stage_stall[k].
  - allow_k = ~valid_k | (ready_go_k & allow_{k+1}), with allow_STAGES = out_allow.
  - in_allow = allow_0.
- Advance: when allow_k, stage k loads from stage k-1, or from the in_* ports for k=0. The loaded valid is valid_{k-1} & ready_go_{k-1}, or in_valid for k=0.
- When ~allow_k, stage k holds all fields.
- Result capture: if valid_k & ~rvld_k & res_ready[k], then res_k <= slice k of res_data and rvld_k <= 1. This applies only while the stage holds.
- On advance, the effective result travels with the entry:
  - value: rvld_{k-1} ? res_{k-1} : slice k-1 of res_data;
  - rvld: rvld_{k-1} | res_ready[k-1].
  - Stage 0 loads with rvld = 0.
- Flush: flush_mask[k] forces valid_k <= 0 at the edge. Flush overrides load, hold and capture. Other fields are don't-care.
- Bypass (combinational, per port p):
  - A candidate is a stage with valid_k & wen_k & wtag_k == rtag_p & rtag_p != 0.
  - The lowest index (youngest) candidate wins.
  - Winner's effective result is rvld_k ? res_k : (res_ready[k] ? slice k : none).
  - If a result exists: fwd_hit_p = 1 and fwd_data_p = that result.
  - If no result exists: fwd_hit_p = 1, fwd_data_p = 0, and that port contributes to fwd_stall.
  - With no candidate: fwd_hit_p = 0 and fwd_data_p = 0.
- fwd_stall = OR of both ports' unresolved hits.
- out_* reflect stage STAGES-1.
- out_res = rvld ? res : slice STAGES-1 of res_data.

## Timing
- Reset: all valid_k = 0 and all rvld_k = 0. Consequently out_valid = 0, out_wen = 0, in_allow = 1, fwd_hit* = 0, fwd_stall = 0, debug_stage_valid = 0.
- Latency is STAGES cycles from in_valid & in_allow to out_valid with no stalls.
- Throughput is 1 per cycle.
- allow is combinational from stage_stall and out_allow. There is no registered bubble.
- A stall in stage k back-pressures stages 0..k in the same cycle. Stages above k continue to drain, and a bubble enters stage k+1.
- Simultaneous flush and advance into stage k: the stage is empty next cycle. Upstream still sees allow_k = 1, so the entry is consumed and dropped.
- flush_mask[0] with in_valid: the entry is dropped, and in_allow is unchanged.
- A result produced in the same cycle as the advance is not lost: it is captured into stage k+1.
- Reset mid-operation clears all entries at that edge. Reset overrides flush and stall.

## Test plan
- STAGES=4, stream tags 1..8 with out_allow=1 and no stalls -> out_valid rises 4 cycles after the first in_valid, then tags 1..8 appear on consecutive cycles.
- Hold stage_stall[2]=1 for 3 cycles with a full pipe -> stages 0-2 hold and in_allow=0. Stage 3 drains, out_valid drops for 3 cycles, and order is preserved.
- Stage 1 holds tag 5 with wen=1 and no result, rtag0=5 -> fwd_hit0=1, fwd_stall=1. Pulse res_ready[1] with 0xDEAD -> same cycle fwd_data0=0xDEAD and fwd_stall=0. The value persists after the stage advances.
- Stage 0 and stage 2 both write tag 7, with results 0x11 and 0x22 -> fwd_data1=0x11 (youngest wins). rtag=0 -> fwd_hit=0.
- flush_mask=4'b0011 while in_valid=1 and all stages full -> next cycle valid[1:0]=0 and valid[3:2] are advanced entries. A stage 1 entry that was a forward candidate no longer hits.
- Assert reset for 1 cycle with a full pipe and stalls active -> next cycle debug_stage_valid=0, in_allow=1, out_valid=0.
